// File: rtl/sobel_stream_pkg.sv
// -----------------------------------------------------------------------------
// sobel_stream_pkg
// Shared definitions for the grayscale pixel stream used by the pixel stream
// source and the Sobel filter.
//   DEF_IMG_W / DEF_IMG_H : default frame geometry (pixels per row / rows)
//   PIX_W                 : pixel width in bits
//   stream_state_e        : stream sequencer states (IDLE, RUN, GAP)
//   cnt_width()           : counter width for a modulus, never below 1 bit
// -----------------------------------------------------------------------------
package sobel_stream_pkg;

  localparam int DEF_IMG_W = 256;
  localparam int DEF_IMG_H = 256;
  localparam int PIX_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } stream_state_e;

  // Width of a counter that must hold 0..n-1. A modulus of 0 or 1 still
  // gets a 1-bit counter so that no vector collapses to zero width.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_ram.sv
// -----------------------------------------------------------------------------
// frame_ram
// Single-clock simple dual-port frame store: one synchronous write port and
// one registered read port. The read register only updates on rd_en, so the
// last pixel read stays on rd_data between reads.
//   clk, rst   : clock, asynchronous active-high reset (read register only)
//   wr_en      : write strobe
//   wr_addr    : write address
//   wr_data    : write data
//   rd_en      : read strobe; rd_data updates on the next rising edge
//   rd_addr    : read address
//   rd_data    : registered read data
// -----------------------------------------------------------------------------
module frame_ram #(
  parameter int DEPTH  = 65536,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset so it maps onto block RAM; only the
  // read register below is reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // NOTE: sequential state is always assigned with <= so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/pixel_stream_source.sv
// -----------------------------------------------------------------------------
// pixel_stream_source
// Frame-buffered pixel stream transmitter. Holds one IMG_W x IMG_H frame that
// is loaded through the write port while idle; on start it replays the frame
// in raster order with LINE_GAP idle cycles after each row.
//   clk, rst     : clock, asynchronous active-high reset
//   wr_en        : frame write strobe (ignored while busy)
//   wr_addr      : write address, row*IMG_W+col
//   wr_data      : write pixel
//   start        : begin one frame replay (only accepted in IDLE)
//   stall        : hold the stream; registered, so it takes effect one cycle
//                  after it is sampled
//   pixel_out    : streamed pixel (holds its value when pixel_valid is low)
//   pixel_valid  : pixel_out valid this cycle
//   sof/eol/eof  : first pixel of frame / last of row / last of frame
//   busy         : high from start acceptance until the last pixel presented
//   done         : one-cycle pulse after the last pixel
// -----------------------------------------------------------------------------
module pixel_stream_source
  import sobel_stream_pkg::*;
#(
  parameter int IMG_W    = DEF_IMG_W,
  parameter int IMG_H    = DEF_IMG_H,
  parameter int LINE_GAP = 2,
  parameter int ADDR_W   = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              start,
  input  logic              stall,
  output logic [PIX_W-1:0]  pixel_out,
  output logic              pixel_valid,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic              busy,
  output logic              done
);

  localparam int COL_W = cnt_width(IMG_W);
  localparam int ROW_W = cnt_width(IMG_H);
  localparam int GAP_W = cnt_width(LINE_GAP);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  // Only meaningful when LINE_GAP > 0; GAP is never entered otherwise.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(LINE_GAP - 1);

  stream_state_e     state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              stall_q;

  logic              rd_en;
  logic              rd_sof;
  logic              rd_eol;
  logic              rd_eof;
  logic              ram_we;

  // Frame loads are locked out for the whole replay so the streamed frame
  // is always the one that was present when start was accepted.
  assign ram_we = wr_en && !busy;

  frame_ram #(
    .DEPTH  (IMG_W * IMG_H),
    .ADDR_W (ADDR_W),
    .DATA_W (PIX_W)
  ) u_frame_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (ram_we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (addr_q),
    .rd_data (pixel_out)
  );

  // ---------------------------------------------------------------------------
  // State and counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      gap_q   <= '0;
      addr_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      gap_q   <= gap_d;
      addr_q  <= addr_d;
      stall_q <= stall;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and read-issue logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default before the case, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    gap_d   = gap_q;
    addr_d  = addr_q;
    rd_en   = 1'b0;
    rd_sof  = 1'b0;
    rd_eol  = 1'b0;
    rd_eof  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          col_d   = '0;
          row_d   = '0;
          gap_d   = '0;
          addr_d  = '0;
        end
      end

      ST_RUN: begin
        // The running address replaces a row*IMG_W+col multiply; raster
        // order means it simply increments on every read.
        if (!stall_q) begin
          rd_en  = 1'b1;
          rd_sof = (col_q == '0) && (row_q == '0);
          rd_eol = (col_q == COL_LAST);
          rd_eof = rd_eol && (row_q == ROW_LAST);

          if (rd_eof) begin
            state_d = ST_IDLE;
            col_d   = '0;
            row_d   = '0;
            addr_d  = '0;
          end else if (rd_eol) begin
            col_d  = '0;
            row_d  = row_q + ROW_W'(1);
            addr_d = addr_q + ADDR_W'(1);
            if (LINE_GAP > 0) begin
              state_d = ST_GAP;
              gap_d   = '0;
            end
          end else begin
            col_d  = col_q + COL_W'(1);
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end

      ST_GAP: begin
        // Stall is deliberately ignored here: the gap always lasts exactly
        // LINE_GAP cycles.
        if (gap_q == GAP_LAST) begin
          state_d = ST_RUN;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output registers: the markers travel one cycle alongside the RAM read so
  // they line up with pixel_out. busy follows the next state, so it drops on
  // the edge that presents the eof pixel; done is eof delayed by one edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_valid <= 1'b0;
      sof         <= 1'b0;
      eol         <= 1'b0;
      eof         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      pixel_valid <= rd_en;
      sof         <= rd_sof;
      eol         <= rd_eol;
      eof         <= rd_eof;
      busy        <= (state_d != ST_IDLE);
      done        <= eof;
    end
  end

endmodule

// File: tb/tb_pixel_stream_source.sv
// -----------------------------------------------------------------------------
// tb_pixel_stream_source
// Two instances on a 4x3 frame: dut_a with LINE_GAP=2, dut_b with LINE_GAP=0.
// Expected pixels and markers are queued when a frame is started and compared
// as valid pixels come out; frame-level timing comes from a vector table.
// -----------------------------------------------------------------------------
module tb_pixel_stream_source;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int AW = 4;

  typedef struct packed {
    logic [7:0] pix;
    logic       sof;
    logic       eol;
    logic       eof;
  } exp_t;

  typedef struct {
    bit    use_b;
    int    stall_after;
    int    stall_len;
    int    exp_len;
    string name;
  } frame_vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en_a = 1'b0;
  logic          wr_en_b = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic          start_a = 1'b0;
  logic          start_b = 1'b0;
  logic          stall = 1'b0;

  logic [7:0] a_pixel_out, b_pixel_out;
  logic       a_pixel_valid, a_sof, a_eol, a_eof, a_busy, a_done;
  logic       b_pixel_valid, b_sof, b_eol, b_eof, b_busy, b_done;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  logic [7:0] mem_model [N];

  always #5 clk = ~clk;

  pixel_stream_source #(.IMG_W(W), .IMG_H(H), .LINE_GAP(2), .ADDR_W(AW)) dut_a (
    .clk (clk), .rst (rst), .wr_en (wr_en_a), .wr_addr (wr_addr), .wr_data (wr_data),
    .start (start_a), .stall (stall), .pixel_out (a_pixel_out), .pixel_valid (a_pixel_valid),
    .sof (a_sof), .eol (a_eol), .eof (a_eof), .busy (a_busy), .done (a_done)
  );

  pixel_stream_source #(.IMG_W(W), .IMG_H(H), .LINE_GAP(0), .ADDR_W(AW)) dut_b (
    .clk (clk), .rst (rst), .wr_en (wr_en_b), .wr_addr (wr_addr), .wr_data (wr_data),
    .start (start_b), .stall (stall), .pixel_out (b_pixel_out), .pixel_valid (b_pixel_valid),
    .sof (b_sof), .eol (b_eol), .eof (b_eof), .busy (b_busy), .done (b_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input bit to_b);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.pix = mem_model[i];
      e.sof = (i == 0);
      e.eol = ((i % W) == W - 1);
      e.eof = (i == N - 1);
      if (to_b) q_b.push_back(e);
      else      q_a.push_back(e);
    end
  endtask

  task automatic wait_done_a(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (a_done) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, seen, 1'b1);
    tick();
  endtask

  // Scoreboards: each valid pixel pops one expected record.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_pixel_valid) begin
        if (q_a.size() == 0) begin
          check("a_unexpected_pixel", a_pixel_out, 32'hDEAD);
        end else begin
          e_a = q_a.pop_front();
          check("a_pixel", a_pixel_out, e_a.pix);
          check("a_markers", {a_sof, a_eol, a_eof}, {e_a.sof, e_a.eol, e_a.eof});
        end
      end else begin
        check("a_markers_idle", {a_sof, a_eol, a_eof}, 3'b000);
      end
      if (b_pixel_valid) begin
        if (q_b.size() == 0) begin
          check("b_unexpected_pixel", b_pixel_out, 32'hDEAD);
        end else begin
          e_b = q_b.pop_front();
          check("b_pixel", b_pixel_out, e_b.pix);
          check("b_markers", {b_sof, b_eol, b_eof}, {e_b.sof, e_b.eol, e_b.eof});
        end
      end else begin
        check("b_markers_idle", {b_sof, b_eol, b_eof}, 3'b000);
      end
    end
  end

  function automatic frame_vec_t mk_vec(input bit use_b, input int stall_after,
                                        input int stall_len, input int exp_len,
                                        input string name);
    frame_vec_t v;
    v.use_b       = use_b;
    v.stall_after = stall_after;
    v.stall_len   = stall_len;
    v.exp_len     = exp_len;
    v.name        = name;
    return v;
  endfunction

  // Runs one frame and measures its timing in cycles after the start edge.
  task automatic run_vec(input frame_vec_t v);
    int   npix = 0, sof_cyc = -1, eof_cyc = -1, done_cyc = -1;
    int   busy_cnt = 0, done_cnt = 0, stall_left = 0;
    bit   stalled = 1'b0;
    logic valid, s, e, b, d;
    push_frame(v.use_b);
    if (v.use_b) start_b = 1'b1;
    else         start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (cyc > 0) tick();
      valid = v.use_b ? b_pixel_valid : a_pixel_valid;
      s     = v.use_b ? b_sof  : a_sof;
      e     = v.use_b ? b_eof  : a_eof;
      b     = v.use_b ? b_busy : a_busy;
      d     = v.use_b ? b_done : a_done;
      if (b) busy_cnt++;
      if (d) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (valid) begin
        npix++;
        if (s && sof_cyc < 0) sof_cyc = cyc;
        if (e) eof_cyc = cyc;
      end
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) stall = 1'b0;
      end else if (!stalled && valid && v.stall_len > 0 && npix == v.stall_after + 1) begin
        stall      = 1'b1;
        stall_left = v.stall_len;
        stalled    = 1'b1;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    stall = 1'b0;
    check({v.name, "_sof_cycle"},  sof_cyc,  1);
    check({v.name, "_eof_cycle"},  eof_cyc,  v.exp_len);
    check({v.name, "_busy_cycles"}, busy_cnt, v.exp_len);
    check({v.name, "_done_cycle"}, done_cyc, v.exp_len + 1);
    check({v.name, "_done_pulses"}, done_cnt, 1);
    check({v.name, "_pixel_count"}, npix, N);
    check({v.name, "_queue_empty"}, v.use_b ? q_b.size() : q_a.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_vec_t vecs[4];
    bit         found;
    int         done_cnt;

    // Frame timing: G=2 gives 12 + 2*2 = 16 cycles, G=0 gives 12; a 3-cycle
    // stall adds 3 bubble cycles.
    vecs[0] = mk_vec(1'b0, -1, 0, 16, "g2_plain");
    vecs[1] = mk_vec(1'b1, -1, 0, 12, "g0_plain");
    vecs[2] = mk_vec(1'b0,  4, 3, 19, "g2_stall");
    vecs[3] = mk_vec(1'b1,  5, 3, 15, "g0_stall");

    #22;
    check("reset_a_outputs", {a_pixel_out, a_pixel_valid, a_sof, a_eol, a_eof, a_busy, a_done}, 0);
    check("reset_b_outputs", {b_pixel_out, b_pixel_valid, b_sof, b_eol, b_eof, b_busy, b_done}, 0);
    tick();
    rst = 1'b0;
    tick();

    // Load pixel value = address into both frames.
    for (int i = 0; i < N; i++) begin
      wr_en_a = 1'b1;
      wr_en_b = 1'b1;
      wr_addr = AW'(i);
      wr_data = 8'(i);
      mem_model[i] = 8'(i);
      tick();
    end
    wr_en_a = 1'b0;
    wr_en_b = 1'b0;
    tick();

    foreach (vecs[i]) begin
      run_vec(vecs[i]);
      tick();
    end

    // start and a write to addr 5 mid-frame are both ignored.
    push_frame(1'b0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    tick();
    start_a = 1'b1;
    wr_en_a = 1'b1;
    wr_addr = AW'(5);
    wr_data = 8'hAA;
    tick();
    start_a = 1'b0;
    wr_en_a = 1'b0;
    wait_done_a("midframe_done");
    for (int i = 0; i < 4; i++) tick();
    check("midframe_start_not_queued", {a_busy, a_pixel_valid}, 2'b00);
    check("midframe_queue_empty", q_a.size(), 0);
    push_frame(1'b0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done_a("second_frame_done");
    check("second_frame_queue_empty", q_a.size(), 0);

    // Reset right after pixel 6 is presented.
    push_frame(1'b0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (a_pixel_valid && a_pixel_out == 8'd6) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_saw_pixel6", found, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_outputs_clear", {a_pixel_out, a_pixel_valid, a_sof, a_eol, a_eof, a_busy, a_done}, 0);
    q_a.delete();
    tick();
    tick();
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (a_done || a_pixel_valid || a_busy) done_cnt++;
    end
    check("rst_no_done_no_activity", done_cnt, 0);
    push_frame(1'b0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done_a("after_rst_done");
    check("after_rst_queue_empty", q_a.size(), 0);

    // Write addr 0 = 0xFF in the same cycle as start.
    mem_model[0] = 8'hFF;
    push_frame(1'b0);
    wr_en_a = 1'b1;
    wr_addr = '0;
    wr_data = 8'hFF;
    start_a = 1'b1;
    tick();
    wr_en_a = 1'b0;
    start_a = 1'b0;
    wait_done_a("write_with_start_done");
    check("write_with_start_queue_empty", q_a.size(), 0);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
